// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and alignment helper
// for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Half needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extraction with sign/zero extension for
// loads, and byte/half merge into a previously read word for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane for loads and overwrite it for stores.
  always_comb begin
    byte_v     = word[{lane, 3'b000} +: 8];
    half_v     = word[{lane[1], 4'b0000} +: 16];
    load_data  = '0;
    store_word = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer in front of a
// word-wide, combinationally read data memory. Sub-word stores are done as
// read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise the address is forced down to alignment.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | ready for a request
// ST_READ  | memory read, word captured at end of cycle
// ST_WRITE | memory write of full or merged word
// ST_RESP  | one-cycle response (data / error)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;

  logic        accept;
  logic        req_err;
  logic [31:0] eff_addr;
  logic [32:0] last_byte;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept = req_valid_i & req_ready_o;

  // Classify the incoming request and compute the address actually used.
  always_comb begin
    last_byte = {1'b0, req_addr_i[31:2], 2'b00} + 33'd3;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err  = (req_size_i == SZ_BAD) || (last_byte >= 33'(MEM_BYTES)) ||
               is_misaligned(req_size_i, req_addr_i[1:0]);
    eff_addr = req_addr_i;
`else
    req_err  = (req_size_i == SZ_BAD) || (last_byte >= 33'(MEM_BYTES));
    eff_addr = req_addr_i;
    if (req_size_i == SZ_HALF)      eff_addr = {req_addr_i[31:1], 1'b0};
    else if (req_size_i == SZ_WORD) eff_addr = {req_addr_i[31:2], 2'b00};
`endif
  end

  // Sequencer: request capture, memory read capture and state transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= eff_addr;
            wdata_q <= req_wdata_i;
            err_q   <= req_err;
            if (req_err)                                   state <= ST_RESP;
            else if (req_we_i && (req_size_i == SZ_WORD))  state <= ST_WRITE;
            else                                           state <= ST_READ;
          end
        end
        ST_READ: begin
          word_q <= mem_rdata_i;
          state  <= we_q ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .word        (word_q),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Decode outputs from registered state; reset forces everything quiet.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_IDLE: req_ready_o = 1'b1;
        ST_READ: begin
          mem_read_o = 1'b1;
          mem_addr_o = {addr_q[31:2], 2'b00};
        end
        ST_WRITE: begin
          mem_write_o = 1'b1;
          mem_addr_o  = {addr_q[31:2], 2'b00};
          mem_wdata_o = store_word;
        end
        default: begin
          rsp_valid_o = 1'b1;
          rsp_err_o   = err_q;
          if (!err_q && !we_q) rsp_rdata_o = load_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-array reference memory model.
module tb_load_store_unit;

  localparam int MB = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_rdata_i;

  logic [7:0]  mem     [MB];
  logic [7:0]  ref_mem [MB];
  logic        mem_clear;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_write_o    (mem_write_o),
    .mem_read_o     (mem_read_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Data memory: combinational read, little-endian word write on the edge.
  always_comb begin
    mem_rdata_i = '0;
    if (mem_addr_o <= 32'(MB - 4))
      for (int i = 0; i < 4; i++) mem_rdata_i[8*i +: 8] = mem[int'(mem_addr_o) + i];
  end

  always @(posedge clk_i) begin
    if (mem_clear) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    end else if (mem_write_o && (mem_addr_o <= 32'(MB - 4))) begin
      for (int i = 0; i < 4; i++) mem[int'(mem_addr_o) + i] <= mem_wdata_o[8*i +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules; updates ref_mem for stores.
  // rk/wk are the cycle (after the accepting edge) of the read/write pulse.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int rk, output int wk);
    int     nb;
    longint base;
    logic   mis;
    int     ea;
    logic [31:0] val;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis  = ((size == 2'd1) && (addr % 2 != 0)) || ((size == 2'd2) && (addr % 4 != 0));
    base = longint'(addr) - longint'(addr % 4);
    err  = (size == 2'd3) || (base + 3 >= MB);
`ifdef LSU_MISALIGN_TRAP_EN
    err  = err || mis;
`endif
    rdata = '0;
    if (err) begin
      lat = 1; rk = 0; wk = 0;
    end else begin
      ea = int'(addr - (addr % nb));
      if (!we) begin
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[ea + i];
        if (!uns && nb < 4 && val[8*nb-1])
          for (int i = 8*nb; i < 32; i++) val[i] = 1'b1;
        rdata = val;
        lat = 2; rk = 1; wk = 0;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[ea + i] = wdata[8*i +: 8];
        if (nb == 4) begin lat = 2; rk = 0; wk = 1; end
        else         begin lat = 3; rk = 1; wk = 2; end
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag,
                        output logic [31:0] obs_rdata, output logic obs_err);
    logic        e_err;
    logic [31:0] e_rdata;
    int e_lat, e_rk, e_wk;
    int lat, rk, wk;
    model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_rk, e_wk);
    @(negedge clk_i);
    check({tag, "/idle_rsp"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "/ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = 0; rk = 0; wk = 0;
    obs_rdata = 'x; obs_err = 1'bx;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_i);
      if (mem_read_o && rk == 0)  rk = k;
      if (mem_write_o && wk == 0) wk = k;
      if (rsp_valid_o) begin
        lat = k;
        obs_rdata = rsp_rdata_o;
        obs_err   = rsp_err_o;
        break;
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'(e_lat));
    check({tag, "/read_cyc"}, 32'(rk), 32'(e_rk));
    check({tag, "/write_cyc"}, 32'(wk), 32'(e_wk));
    check({tag, "/err"}, 32'(obs_err), 32'(e_err));
    check({tag, "/rdata"}, obs_rdata, e_rdata);
    check({tag, "/ready_in_rsp"}, 32'(req_ready_o), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] pre;
    logic        rsp_seen;

    rst_i = 1'b1; mem_clear = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;

    // Reset state, including a request presented during reset.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    #1;
    check("rst/ready", 32'(req_ready_o), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst/rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst/rdata", rsp_rdata_o, 32'd0);
    check("rst/mem_rw", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    check("rst/mem_addr", mem_addr_o, 32'd0);
    check("rst/mem_wdata", mem_wdata_o, 32'd0);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; mem_clear = 1'b0;

    // Directed scenarios.
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, "st_w08", rd, er);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, "ld_w08", rd, er);
    check("ld_w08/const", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h80, "st_b09", rd, er);
    check("st_b09/mem_word", mem_word(8), 32'hDEAD80EF);
    do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, "ld_b09_s", rd, er);
    check("ld_b09_s/const", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, "ld_b09_u", rd, er);
    check("ld_b09_u/const", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, "ld_h0a", rd, er);
    check("ld_h0a/const", rd, 32'hFFFFDEAD);
    do_req(1'b0, 2'b01, 1'b0, 32'h0B, 32'h0, "ld_h0b", rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("ld_h0b/const_err", 32'(er), 32'd1);
`else
    check("ld_h0b/const_rd", rd, 32'hFFFFDEAD);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, "ld_w1c", rd, er);
    check("ld_w1c/const_err", 32'(er), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "ld_w20", rd, er);
    check("ld_w20/const_err", 32'(er), 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678, "st_bad", rd, er);

    // Reset during the WRITE cycle of a sub-word store aborts it.
    pre = mem_word(4);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b01;
    req_unsigned_i = 1'b0; req_addr_i = 32'h06; req_wdata_i = 32'hA5A5C3C3;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("abort/write_before_rst", 32'(mem_write_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("abort/write_in_rst", 32'(mem_write_o), 32'd0);
    check("abort/wdata_in_rst", mem_wdata_o, 32'd0);
    check("abort/addr_in_rst", mem_addr_o, 32'd0);
    @(negedge clk_i);
    check("abort/rsp_in_rst", 32'(rsp_valid_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("abort/ready_after", 32'(req_ready_o), 32'd1);
    rsp_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) rsp_seen = 1'b1;
    end
    check("abort/no_rsp", 32'(rsp_seen), 32'd0);
    check("abort/mem_unchanged", mem_word(4), pre);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 39));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $sformatf("rnd%0d", n), rd, er);
    end

    // Final memory image must match the model byte for byte.
    @(negedge clk_i);
    for (int i = 0; i < MB; i++)
      check($sformatf("mem_final[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 32, data-memory size in bytes (multiple of 4, >=4).
REQ-002 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid_i in 1 / req_ready_o out 1  request handshake.
REQ-005 SHALL have ports req_we_i in 1 (1=store), req_size_i in 2 (00 byte, 01 half, 10 word, 11 illegal), req_unsigned_i in 1 (load zero-extend).
REQ-006 SHALL have ports req_addr_i in 32 (byte address) and req_wdata_i in 32 (store data, LSB-justified).
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_rdata_o out 32, rsp_err_o out 1  completion.
REQ-008 SHALL have memory-side ports mem_addr_o out 32, mem_wdata_o out 32, mem_write_o out 1, mem_read_o out 1, mem_rdata_i in 32. The memory reads combinationally, writes 4 bytes little-endian on the clock edge when write is high.

Function
REQ-009 SHALL implement states IDLE, READ, WRITE, RESP. req_ready_o=1 only in IDLE with rst_i low.
REQ-010 SHALL accept a request on an edge with req_valid_i&req_ready_o and register all req_* fields.
REQ-011 SHALL classify an accepted request as an error when: size=11; half with addr[0]=1; word with addr[1:0]!=0; or (addr&~3)+3 >= MEM_BYTES.
REQ-012 SHALL sequence IDLE->RESP for an error, IDLE->READ->RESP for a load, IDLE->WRITE->RESP for a word store, and IDLE->READ->WRITE->RESP for a byte/half store (read-modify-write).
REQ-013 SHALL drive mem_addr_o=addr&~3 in READ and WRITE, and 0 otherwise.
REQ-014 SHALL drive mem_read_o=1 only in READ, and SHALL capture mem_rdata_i into a word register at the end of READ.
REQ-015 SHALL drive mem_write_o=1 only in WRITE with rst_i low. mem_wdata_o SHALL be req_wdata for a word store; otherwise it SHALL be the captured word with lane addr[1:0] (byte) or addr[1] (half) replaced by the low 8/16 bits of req_wdata. mem_wdata_o SHALL be 0 outside WRITE.
REQ-016 SHALL assert rsp_valid_o for exactly one cycle in RESP, with no backpressure, then return to IDLE.
REQ-017 For a load, rsp_rdata_o SHALL carry the selected lane, sign-extended, or zero-extended when req_unsigned_i=1. For stores and errors it SHALL be 0.
REQ-018 rsp_err_o SHALL be 1 in RESP only for error requests. An error request SHALL never assert mem_read_o or mem_write_o.
REQ-019 Latency from the accepting edge to rsp_valid_o: error 1, load 2, word store 2, sub-word store 3 cycles.
REQ-020 Back-to-back: a new request SHALL be accepted on the edge leaving RESP at the earliest, i.e. the first IDLE cycle.

Reset
REQ-021 While rst_i=1: state SHALL go to IDLE at the edge; req_ready_o, rsp_valid_o, rsp_err_o, mem_read_o and mem_write_o SHALL be 0; rsp_rdata_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-022 Reset mid-operation SHALL abort the transaction: no memory write at or after the edge where rst_i is sampled high, and no response for the aborted request.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN. When defined, misalignment is an error per REQ-011.
REQ-024 When the macro is undefined, misaligned half/word requests SHALL proceed with the address forced down (half &~1, word &~3), rsp_err_o=0. Size=11 and range errors remain.

Structure
REQ-025 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-026 Lane extract/sign-extend and store merge SHALL live in combinational sub-module lsu_lane_align. The FSM and registers SHALL stay in load_store_unit.

Verification
REQ-027 Word store addr 0x08, data 0xDEADBEEF, then word load 0x08 -> memory write at accept+1, load rsp_rdata_o=0xDEADBEEF at accept+2, err=0.
REQ-028 Byte store 0x80 to addr 0x09 over word 0xDEADBEEF -> READ then WRITE of 0xDEAD80EF. A signed byte load of 0x09 returns 0xFFFFFF80; unsigned returns 0x00000080.
REQ-029 Half load addr 0x0A signed over 0xDEAD80EF -> 0xFFFFDEAD. Half load at 0x0B with macro defined -> err=1 at accept+1 and no mem_read_o pulse.
REQ-030 Word load addr 0x1C -> OK. Word load addr 0x20 (MEM_BYTES=32) -> err=1, rdata=0.
REQ-031 rst_i asserted during the WRITE cycle of a sub-word store -> mem_write_o=0 that cycle, memory unchanged, no rsp_valid_o, req_ready_o=1 in the first cycle after rst_i drops.
